store_buffer: RTL

- Write-posting buffer between the MEM pipeline stage and the byte-addressed data memory.
- Accepts 32-bit word stores from the MEM stage, queues them in program order and drains one per cycle to the memory's single write port when the port is free.
- Loads still read the memory directly, but are checked against pending entries for forwarding or stall.
- Provides a fence handshake that empties the buffer before the pipeline continues.

---
 rtl/sb_pkg.sv | 24 ++
 rtl/sb_addr_cmp.sv | 27 ++
 rtl/store_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: entry layout, control states
// and pointer sizing.
package sb_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int SB_MAX_ADDR_W  = 64;

    typedef enum logic {
        SB_NORMAL = 1'b0,
        SB_FENCE  = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic                     valid;
        logic [SB_MAX_ADDR_W-1:0] addr;
        logic [31:0]              data;
    } sb_entry_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_addr_cmp.sv
// Per-entry address comparator: flags an exact word match or a partial byte
// overlap between a pending 4-byte store and a 4-byte load.
module sb_addr_cmp
    import sb_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              valid,
    input  logic [ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              exact,
    output logic              overlap
);

    logic [ADDR_W-1:0] fwd_dist;
    logic [ADDR_W-1:0] rev_dist;
    logic              touch;

    // Two 4-byte windows intersect when their start addresses differ by < 4.
    assign fwd_dist = entry_addr - ld_addr;
    assign rev_dist = ld_addr - entry_addr;
    assign touch    = (fwd_dist < ADDR_W'(WORD_BYTES)) || (rev_dist < ADDR_W'(WORD_BYTES));

    assign exact    = valid && (entry_addr == ld_addr);
    assign overlap  = valid && touch && (entry_addr != ld_addr);

endmodule

// File: rtl/store_buffer.sv
// Write-posting store buffer between MEM and data memory, with load
// forward/stall checking and a fence drain. Forwarding: STORE_BUFFER_FWD_EN.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_fwd_data,
    output logic              ld_stall,
    input  logic              fence_req,
    output logic              fence_done,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sb_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries_reg [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    sb_state_t        state_reg;
    sb_state_t        state_next;
    logic             fence_done_reg;
    logic             fence_done_next;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] exact_vec;
    logic [DEPTH-1:0] overlap_vec;
    logic             exact_any;
    logic             overlap_any;
    sb_entry_t        head_entry;
    logic             unused_st_data;

    assign unused_st_data = ^st_data[DATA_W-1:32];

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign st_ready = !full && (state_reg == SB_NORMAL);
    assign push     = st_valid && st_ready;

    // A stalled load does not use the port, so the head may drain under it.
    assign mem_write = !empty && ((state_reg == SB_FENCE) || !ld_valid || ld_stall);
    assign pop       = mem_write;

    assign head_entry = entries_reg[head_reg];
    assign mem_addr   = empty ? '0 : head_entry.addr[ADDR_W-1:0];
    assign mem_wdata  = empty ? '0 : DATA_W'(head_entry.data);
    assign sb_empty   = empty;
    assign fence_done = fence_done_reg;

    assign count_next = count_reg + CW'(push) - CW'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            sb_addr_cmp #(
                .ADDR_W (ADDR_W)
            ) u_cmp (
                .valid      (entries_reg[gi].valid),
                .entry_addr (entries_reg[gi].addr[ADDR_W-1:0]),
                .ld_addr    (ld_addr),
                .exact      (exact_vec[gi]),
                .overlap    (overlap_vec[gi])
            );

            // Push and pop never target the same slot: push needs !full,
            // pop needs !empty, and they only coincide at those extremes.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entries_reg[gi] <= '0;
                end else if (push && (tail_reg == PW'(gi))) begin
                    entries_reg[gi] <= '{valid: 1'b1,
                                         addr:  SB_MAX_ADDR_W'(st_addr),
                                         data:  st_data[31:0]};
                end else if (pop && (head_reg == PW'(gi))) begin
                    entries_reg[gi].valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign exact_any   = |exact_vec;
    assign overlap_any = |overlap_vec;

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] scan_idx;
    logic [31:0]   fwd_word;

    // Walk oldest to youngest so the last exact match (nearest tail) wins.
    always_comb begin
        scan_idx = head_reg;
        fwd_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PW'(k);
            if (exact_vec[scan_idx]) begin
                fwd_word = entries_reg[scan_idx].data;
            end
        end
    end
`endif

    always_comb begin
        ld_stall    = 1'b0;
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        if (ld_valid) begin
            if (state_reg == SB_FENCE) begin
                ld_stall = 1'b1;
            end else if (overlap_any) begin
                ld_stall = 1'b1;
            end else if (exact_any) begin
`ifdef STORE_BUFFER_FWD_EN
                ld_hit      = 1'b1;
                ld_fwd_data = DATA_W'(fwd_word);
`else
                ld_stall    = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        fence_done_next = 1'b0;
        case (state_reg)
            SB_NORMAL: begin
                if (fence_req) begin
                    if (empty) begin
                        fence_done_next = 1'b1;
                    end else begin
                        state_next = SB_FENCE;
                    end
                end
            end
            SB_FENCE: begin
                // Checked on count_next so a buffer that emptied on the entry edge still exits.
                if (count_next == '0) begin
                    state_next      = SB_NORMAL;
                    fence_done_next = 1'b1;
                end
            end
            default: state_next = SB_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            state_reg      <= SB_NORMAL;
            fence_done_reg <= 1'b0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg      <= count_next;
            state_reg      <= state_next;
            fence_done_reg <= fence_done_next;
        end
    end

`ifndef SYNTHESIS
    st_ld_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(st_valid && ld_valid))
        else $warning("store_buffer: st_valid and ld_valid both high; store takes priority");
`endif

endmodule
